uart_tx_fifo: RTL and testbench
===============================

# uart_tx_fifo

Byte FIFO between the message sequencer and `uart_tx`. Producers push bytes at clock rate without watching the serialiser. The block issues one byte at a time to `uart_tx` using its `write_enable` / `TC` (transmission complete) handshake. This removes the per-byte TC polling that the top-level sequencer does today.

## Interface
Parameters:
- `DEPTH`, 16: number of byte entries; must be a power of two, at least 2.
- `ADDR_W`, 4: log2(`DEPTH`).

Ports:
- `clk` in 1: single clock; all state changes on its rising edge.
- `reset_bar` in 1: reset, asynchronous and active-low.
- `wr_data` in 8: byte to enqueue.
- `wr_en` in 1: push request; sampled every edge.
- `full` out 1: combinational, `count == DEPTH`.
- `empty` out 1: combinational, `count == 0`.
- `count` out `ADDR_W+1`: current occupancy.
- `tx_data` out 8: byte presented to `uart_tx`. Registered; holds its value between issues.
- `tx_write_enable` out 1: one-cycle registered pulse to `uart_tx`.
- `tx_tc` in 1: `TC` from `uart_tx`. High means idle, or the previous byte is finished.
- `overflow` out 1: sticky drop flag (see Configuration).

## Operation
Push side:
- On each edge, a push is accepted iff `wr_en && !full`. The entry at `wr_ptr` is written and `wr_ptr` increments, wrapping modulo `DEPTH`.
- `wr_en` while `full` is dropped and the FIFO is unchanged. This holds even if a pop happens on the same edge.
- `full` is evaluated from `count` before the edge.

Drain FSM, three states:
- IDLE:
  - If `count != 0 && tx_tc`, then on the edge: `tx_data <= mem[rd_ptr]`, `tx_write_enable <= 1`, `rd_ptr++`, go to BUSY.
  - Otherwise stay in IDLE.
- BUSY:
  - `tx_write_enable <= 0`.
  - Stay until `tx_tc == 0` is sampled, then go to DONE.
- DONE:
  - Stay until `tx_tc == 1` is sampled, then go to IDLE.

Counting:
- A simultaneous accepted push and issue (pop) on one edge leaves `count` unchanged.
- Push alone increments `count`; pop alone decrements it.
- Pointers are `ADDR_W` bits and wrap naturally. `count` never exceeds `DEPTH` and never goes negative.

Reset (`reset_bar` low, asynchronous):
- Pointers = 0, `count` = 0, FSM = IDLE.
- `tx_data` = 8'h00, `tx_write_enable` = 0, `overflow` = 0.
- Memory contents are not reset.
- Reset during BUSY or DONE abandons the in-flight byte. No re-issue follows.

## Timing
- Empty FIFO, `tx_tc` high, push on edge 0: `count` = 1 after edge 0. `tx_write_enable` is high from edge 1 to edge 2, with `tx_data` valid over the same window. `uart_tx` captures the byte on edge 2.
- Back-to-back bytes: the next issue occurs no earlier than the first edge that samples IDLE with `tx_tc` high. This means one serialiser frame plus 1 cycle.
- `tx_write_enable` is never high for two consecutive cycles.
- `tx_write_enable` is never asserted unless `tx_tc` was high on the issuing edge.
- Push-to-`full` latency: 0. `full` reflects the occupancy after the previous edge.

## Configuration
- `UART_TX_FIFO_OVERFLOW_EN` defined:
  - `overflow` is set on any edge with `wr_en && full`.
  - It is cleared only by reset.
- Macro undefined:
  - `overflow` is tied to 0 and its flop is not built.
  - Dropped-push behaviour is otherwise identical.

## Structure
- Shared package/header `uart_defs`:
  - `BYTE_W = 8`.
  - FSM state encodings: IDLE = 2'b00, BUSY = 2'b01, DONE = 2'b10.
  - These are reused by a future `uart_rx` buffer.
- Sub-module `uart_fifo_ram`:
  - `DEPTH`×8 storage, one write port and one asynchronous read port.
  - Pointers and counters stay in `uart_tx_fifo`.
- The FSM and `count` logic live in the top of the block.

## Test plan
- Reset:
  - Hold `reset_bar` low mid-transfer (in BUSY).
  - Expect `count` = 0, `tx_write_enable` = 0, `tx_data` = 00, FSM in IDLE immediately after the assert.
  - Expect no pulse after release.
- Single byte:
  - With `tx_tc` = 1, push 8'hA5 on edge 0.
  - Expect `tx_write_enable` high for exactly the cycle between edges 1 and 2, with `tx_data` = A5.
  - Then drop `tx_tc` for 10 cycles: expect no further pulse. `count` returns to 0.
- Ordering:
  - Push 16 bytes 00..0F with the serialiser model busy.
  - Expect `full` = 1 and `count` = 16.
  - Expect 16 issues in order 00..0F, each spaced by the model's TC low time.
- Overflow:
  - Fill to `DEPTH`, push 8'hFF.
  - Expect `count` = 16 and FF never transmitted.
  - Expect `overflow` = 1 with `UART_TX_FIFO_OVERFLOW_EN`, 0 without.
- Simultaneous:
  - With `count` = 3 and IDLE with `tx_tc` = 1, push on the issuing edge.
  - Expect `count` stays 3, and the pushed byte is transmitted 4th.
- Wrap-around:
  - Push and drain 40 bytes in bursts of 5.
  - Expect the bytes sequence to be transmitted intact across pointer wrap.
  - Expect `empty` = 1 at the end.

Source files
------------

// File: rtl/uart_defs.sv
// Shared UART definitions: byte width and drain/receive FSM state encodings.
// Intended for reuse by both the transmit FIFO and a later receive buffer.
package uart_defs;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StBusy = 2'b01,
    StDone = 2'b10
  } uart_state_e;

endpackage

// File: rtl/uart_fifo_ram.sv
// Byte storage for the UART FIFOs: DEPTH entries, one synchronous write port
// and one asynchronous read port. Contents are not reset.
// Ports:
//   clk_i           clock
//   we_i            write enable (write on rising edge)
//   waddr_i/wdata_i write address / data
//   raddr_i         read address
//   rdata_o         combinational read data
module uart_fifo_ram
  import uart_defs::*;
#(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [BYTE_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [BYTE_W-1:0] rdata_o
);

  logic [BYTE_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding uart_tx. Producers push at clock rate; a three-state drain
// FSM issues one byte at a time using the write_enable / TC handshake.
// Optional feature macro: UART_TX_FIFO_OVERFLOW_EN builds a sticky overflow
// flag set on any push attempted while full; without it overflow is tied 0.
// Ports:
//   clk, reset_bar      clock, asynchronous active-low reset
//   wr_data, wr_en      push byte / request (dropped while full)
//   full, empty, count  occupancy status (combinational from count register)
//   tx_data             registered byte to uart_tx, held between issues
//   tx_write_enable     one-cycle registered issue pulse
//   tx_tc               transmission complete / idle from uart_tx
//   overflow            sticky dropped-push flag
module uart_tx_fifo
  import uart_defs::*;
#(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset_bar,
  input  logic [BYTE_W-1:0] wr_data,
  input  logic              wr_en,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic [BYTE_W-1:0] tx_data,
  output logic              tx_write_enable,
  input  logic              tx_tc,
  output logic              overflow
);

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  uart_state_e       state_q, state_d;
  logic [BYTE_W-1:0] tx_data_q, tx_data_d;
  logic              tx_we_q, tx_we_d;
  logic [BYTE_W-1:0] rd_data;
  logic              push, pop;

  assign full  = (count_q == (ADDR_W+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  // A push while full is dropped even if a pop happens on the same edge.
  assign push  = wr_en && !full;

  uart_fifo_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (push),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_data),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_data)
  );

  // Drain FSM: issue in IDLE, wait for TC to fall (BUSY), then rise (DONE).
  always_comb begin
    state_d   = state_q;
    tx_we_d   = 1'b0;
    tx_data_d = tx_data_q;
    pop       = 1'b0;
    case (state_q)
      StIdle: begin
        if (!empty && tx_tc) begin
          pop       = 1'b1;
          tx_we_d   = 1'b1;
          tx_data_d = rd_data;
          state_d   = StBusy;
        end
      end
      StBusy: begin
        if (!tx_tc) state_d = StDone;
      end
      StDone: begin
        if (tx_tc) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + ADDR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + ADDR_W'(1) : rd_ptr_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + (ADDR_W+1)'(1);
      2'b01:   count_d = count_q - (ADDR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_bar) begin
    if (!reset_bar) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      state_q   <= StIdle;
      tx_data_q <= '0;
      tx_we_q   <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      state_q   <= state_d;
      tx_data_q <= tx_data_d;
      tx_we_q   <= tx_we_d;
    end
  end

  assign tx_data         = tx_data_q;
  assign tx_write_enable = tx_we_q;

`ifdef UART_TX_FIFO_OVERFLOW_EN
  logic overflow_q, overflow_d;

  always_comb begin
    overflow_d = overflow_q | (wr_en & full);
  end

  always_ff @(posedge clk or negedge reset_bar) begin
    if (!reset_bar) begin
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
    end
  end

  assign overflow = overflow_q;
`else
  assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: a table-driven single-byte timing
// sequence, hand-written corner sequences and a randomized phase, all checked
// against a queue-based FIFO model and a simple serialiser model driving tx_tc.
module tb_uart_tx_fifo;

  localparam int unsigned DEPTH = 16;

  logic       clk;
  logic       reset_bar;
  logic [7:0] wr_data;
  logic       wr_en;
  logic       full;
  logic       empty;
  logic [4:0] count;
  logic [7:0] tx_data;
  logic       tx_write_enable;
  logic       tx_tc;
  logic       overflow;

  uart_tx_fifo #(
    .DEPTH  (16),
    .ADDR_W (4)
  ) dut (
    .clk             (clk),
    .reset_bar       (reset_bar),
    .wr_data         (wr_data),
    .wr_en           (wr_en),
    .full            (full),
    .empty           (empty),
    .count           (count),
    .tx_data         (tx_data),
    .tx_write_enable (tx_write_enable),
    .tx_tc           (tx_tc),
    .overflow        (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state.
  logic [7:0]  mq[$];        // bytes accepted and not yet issued
  logic [7:0]  tx_log[$];    // bytes seen on issue pulses
  int          issue_cyc[$]; // cycle index of each issue
  logic        ov_m;
  int          busy;         // serialiser remaining frame cycles (tc low)
  int          frame_len;
  bit          rand_frame;
  bit          force_low;    // hold tc low regardless of serialiser
  int          cyc;
  int          pulse_cnt;

  int n_chk;
  int n_err;

  typedef struct {
    logic       we;
    logic [7:0] d;
    logic [4:0] cnt;
    logic       txwe;
    logic [7:0] txd;
  } vec_t;

  vec_t vec [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic set_force(input bit v);
    force_low = v;
    tx_tc = (busy == 0) && !force_low;
  endtask

  // One clock: drive inputs, let the edge happen, update the model, compare.
  task automatic step(input logic we, input logic [7:0] d);
    bit   full_b;
    logic tc_b;
    logic we_prev;
    wr_en   = we;
    wr_data = d;
    full_b  = (mq.size() == DEPTH);
    tc_b    = tx_tc;
    we_prev = tx_write_enable;
    @(posedge clk);
    #1;
    cyc++;
    if (tx_write_enable) begin
      pulse_cnt++;
      chk("we_not_consecutive", {31'd0, we_prev}, 32'd0);
      chk("tc_high_on_issue", {31'd0, tc_b}, 32'd1);
      if (mq.size() == 0) begin
        chk("issue_from_empty", 32'd1, 32'd0);
      end else begin
        chk("tx_data", {24'd0, tx_data}, {24'd0, mq.pop_front()});
      end
      tx_log.push_back(tx_data);
      issue_cyc.push_back(cyc);
      if (rand_frame) frame_len = $urandom_range(1, 6);
      busy = frame_len;
    end else if (busy > 0) begin
      busy--;
    end
    if (we && !full_b) mq.push_back(d);
`ifdef UART_TX_FIFO_OVERFLOW_EN
    if (we && full_b) ov_m = 1'b1;
`endif
    tx_tc = (busy == 0) && !force_low;
    chk("count", {27'd0, count}, mq.size());
    chk("full", {31'd0, full}, {31'd0, mq.size() == DEPTH});
    chk("empty", {31'd0, empty}, {31'd0, mq.size() == 0});
    chk("overflow", {31'd0, overflow}, {31'd0, ov_m});
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((mq.size() != 0 || busy != 0) && n < 3000) begin
      step(1'b0, 8'h00);
      n++;
    end
    chk("drain_timeout", {31'd0, n < 3000}, 32'd1);
    // Let the FSM pass DONE -> IDLE.
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00);
  endtask

  task automatic clear_logs();
    tx_log.delete();
    issue_cyc.delete();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    n_chk = 0; n_err = 0; cyc = 0; pulse_cnt = 0;
    busy = 0; frame_len = 3; rand_frame = 0; force_low = 0; ov_m = 1'b0;
    reset_bar = 1'b0; wr_en = 1'b0; wr_data = 8'h00; tx_tc = 1'b1;

    // Expected trace from reset for a single push of A5, frame of 3 cycles.
    vec[0] = '{1'b1, 8'hA5, 5'd1, 1'b0, 8'h00};
    vec[1] = '{1'b0, 8'h00, 5'd0, 1'b1, 8'hA5};
    vec[2] = '{1'b0, 8'h00, 5'd0, 1'b0, 8'hA5};
    vec[3] = '{1'b0, 8'h00, 5'd0, 1'b0, 8'hA5};
    vec[4] = '{1'b0, 8'h00, 5'd0, 1'b0, 8'hA5};
    vec[5] = '{1'b0, 8'h00, 5'd0, 1'b0, 8'hA5};
    vec[6] = '{1'b0, 8'h00, 5'd0, 1'b0, 8'hA5};

    // Reset state.
    #12;
    chk("rst_count", {27'd0, count}, 32'd0);
    chk("rst_empty", {31'd0, empty}, 32'd1);
    chk("rst_full", {31'd0, full}, 32'd0);
    chk("rst_we", {31'd0, tx_write_enable}, 32'd0);
    chk("rst_data", {24'd0, tx_data}, 32'd0);
    chk("rst_overflow", {31'd0, overflow}, 32'd0);
    @(posedge clk);
    #1;
    reset_bar = 1'b1;

    // Single byte, table driven.
    for (int i = 0; i < 7; i++) begin
      step(vec[i].we, vec[i].d);
      chk("tbl_count", {27'd0, count}, {27'd0, vec[i].cnt});
      chk("tbl_we", {31'd0, tx_write_enable}, {31'd0, vec[i].txwe});
      chk("tbl_data", {24'd0, tx_data}, {24'd0, vec[i].txd});
    end
    p0 = pulse_cnt;
    set_force(1'b1);
    for (int i = 0; i < 10; i++) step(1'b0, 8'h00);
    set_force(1'b0);
    chk("single_no_extra_pulse", pulse_cnt, p0);
    chk("single_count_zero", {27'd0, count}, 32'd0);

    // Reset while BUSY abandons the byte.
    step(1'b1, 8'h5A);
    step(1'b0, 8'h00);
    chk("pre_reset_pulse", {31'd0, tx_write_enable}, 32'd1);
    reset_bar = 1'b0;
    #1;
    mq.delete(); busy = 0; ov_m = 1'b0; tx_tc = !force_low;
    chk("busy_rst_count", {27'd0, count}, 32'd0);
    chk("busy_rst_we", {31'd0, tx_write_enable}, 32'd0);
    chk("busy_rst_data", {24'd0, tx_data}, 32'd0);
    chk("busy_rst_empty", {31'd0, empty}, 32'd1);
    @(posedge clk);
    #1;
    reset_bar = 1'b1;
    p0 = pulse_cnt;
    for (int i = 0; i < 6; i++) step(1'b0, 8'h00);
    chk("no_reissue_after_reset", pulse_cnt, p0);

    // Ordering and overflow.
    frame_len = 4;
    clear_logs();
    set_force(1'b1);
    for (int i = 0; i < 16; i++) step(1'b1, 8'(i));
    chk("ord_full", {31'd0, full}, 32'd1);
    chk("ord_count", {27'd0, count}, 32'd16);
    step(1'b1, 8'hFF);
    chk("ovf_count", {27'd0, count}, 32'd16);
`ifdef UART_TX_FIFO_OVERFLOW_EN
    chk("ovf_flag", {31'd0, overflow}, 32'd1);
`else
    chk("ovf_flag", {31'd0, overflow}, 32'd0);
`endif
    set_force(1'b0);
    drain();
    chk("ord_n_issued", tx_log.size(), 32'd16);
    for (int i = 0; i < 16 && i < tx_log.size(); i++) begin
      chk("ord_byte", {24'd0, tx_log[i]}, i);
    end
    // frame of 4 tc-low cycles, one cycle in DONE seeing tc high, one in IDLE
    for (int i = 1; i < issue_cyc.size(); i++) begin
      chk("ord_spacing", issue_cyc[i] - issue_cyc[i-1], 32'd6);
    end

    // Simultaneous push on the issuing edge.
    clear_logs();
    set_force(1'b1);
    step(1'b1, 8'h10);
    step(1'b1, 8'h11);
    step(1'b1, 8'h12);
    set_force(1'b0);
    step(1'b1, 8'h13);
    chk("sim_count", {27'd0, count}, 32'd3);
    chk("sim_we", {31'd0, tx_write_enable}, 32'd1);
    drain();
    chk("sim_n_issued", tx_log.size(), 32'd4);
    if (tx_log.size() == 4) chk("sim_fourth", {24'd0, tx_log[3]}, 32'h13);

    // Wrap-around: 40 bytes in bursts of 5.
    begin
      logic [7:0] exp_seq[$];
      clear_logs();
      rand_frame = 1;
      for (int b = 0; b < 8; b++) begin
        for (int i = 0; i < 5; i++) begin
          logic [7:0] v;
          v = 8'($urandom);
          exp_seq.push_back(v);
          step(1'b1, v);
        end
        drain();
      end
      chk("wrap_n_issued", tx_log.size(), 32'd40);
      for (int i = 0; i < 40 && i < tx_log.size(); i++) begin
        chk("wrap_byte", {24'd0, tx_log[i]}, {24'd0, exp_seq[i]});
      end
      chk("wrap_empty", {31'd0, empty}, 32'd1);
    end

    // Randomized traffic against the model.
    clear_logs();
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 9) < 4, 8'($urandom));
    end
    drain();
    chk("rand_empty", {31'd0, empty}, 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
